// File: rtl/hc_pkg.sv
// Shared constants and FSM encoding for the hc148 priority encoder and the CPU-side logic that reuses it.
package hc_pkg;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;
  localparam logic [2:0] EN_ACTIVE = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;
endpackage

// File: rtl/hc148_enc_if.sv
// Request/offer bus between peripheral strobes, the hc148 encoder and its consumer.
interface hc148_enc_if;
  import hc_pkg::*;

  logic [2:0]       enable;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [IDX_W-1:0] code;
  logic             valid;
  logic [WIDTH-1:0] pending;
  logic             any;

  modport master (
    output enable, req, mask, ack,
    input  code, valid, pending, any
  );

  modport slave (
    input  enable, req, mask, ack,
    output code, valid, pending, any
  );
endinterface

// File: rtl/hc148_prio.sv
// Combinational 8->3 highest-set-bit encoder with a found flag.
module hc148_prio
  import hc_pkg::*;
(
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    // Ascending scan so the highest set bit is the last assignment.
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc148_enc.sv
// Registered priority encoder: rising-edge capture into a sticky pending register,
// highest unmasked pending line offered as a code and held until acknowledged.
module hc148_enc
  import hc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  hc148_enc_if.slave  bus
);

  logic [WIDTH-1:0] r_req_q;
  logic [WIDTH-1:0] r_pending;
  logic [IDX_W-1:0] r_code;
  logic             r_valid;
  state_e           r_state;

  logic             w_en;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_elig;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  assign w_en   = (bus.enable == EN_ACTIVE);
  assign w_edge = w_en ? (bus.req & ~r_req_q) : '0;
  assign w_clr  = (r_valid && bus.ack) ? (WIDTH'(1) << r_code) : '0;
  assign w_elig = r_pending & bus.mask;

  hc148_prio u_prio (
    .i_vec   (w_elig),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= bus.req;
      // OR-ing the edge after the clear lets a same-cycle re-rise survive the ack.
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_en && w_found) begin
            r_code  <= w_idx;
            r_valid <= 1'b1;
            r_state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.code    = r_code;
  assign bus.valid   = r_valid;
  assign bus.pending = r_pending;
  assign bus.any     = |w_elig;

endmodule

// File: tb/tb_hc148_enc.sv
// Bench for hc148_enc: directed scenarios plus random traffic against an event-list reference model.
module tb_hc148_enc;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  hc148_enc_if bus();

  hc148_enc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state: last seen request levels, set of outstanding events, current offer.
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  logic       m_offer;
  int         m_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // One clock: apply inputs, predict, clock, compare everything observable.
  task automatic cyc(input logic r, input logic [2:0] en, input logic [7:0] rq,
                     input logic [7:0] mk, input logic ak);
    logic [7:0] n_pend;
    logic       n_offer;
    int         n_code;
    logic       active;
    @(negedge clk);
    rst        = r;
    bus.enable = en;
    bus.req    = rq;
    bus.mask   = mk;
    bus.ack    = ak;
    active  = (en == 3'd7);
    n_pend  = m_pend;
    n_offer = m_offer;
    n_code  = m_code;
    if (r) begin
      n_pend  = 8'h00;
      n_offer = 1'b0;
      n_code  = 0;
    end else begin
      if (m_offer && ak) n_pend[m_code] = 1'b0;
      for (int i = 0; i < 8; i++)
        if (active && rq[i] && !m_prev[i]) n_pend[i] = 1'b1;
      if (!m_offer) begin
        if (active && (m_pend & mk) != 8'h00) begin
          n_offer = 1'b1;
          n_code  = top_bit(m_pend & mk);
        end
      end else if (ak) begin
        n_offer = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_prev  = r ? 8'h00 : rq;
    m_pend  = n_pend;
    m_offer = n_offer;
    m_code  = n_code;
    chk("valid",   bus.valid,   m_offer);
    chk("code",    bus.code,    m_code);
    chk("pending", bus.pending, m_pend);
    chk("any",     bus.any,     (m_pend & mk) != 8'h00);
  endtask

  initial begin
    m_prev = 0; m_pend = 0; m_offer = 0; m_code = 0;
    rst = 1'b1; bus.enable = 3'd0; bus.req = 8'h00; bus.mask = 8'h00; bus.ack = 1'b0;

    // Reset state
    cyc(1, 3'd7, 8'h00, 8'hFF, 0);
    cyc(1, 3'd7, 8'h00, 8'hFF, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_code", bus.code, 0);

    // Single request on line 2, two-cycle latency
    cyc(0, 3'd7, 8'h04, 8'hFF, 0);
    chk("s1_pend", bus.pending, 8'h04);
    chk("s1_nolatch", bus.valid, 0);
    cyc(0, 3'd7, 8'h04, 8'hFF, 0);
    chk("s1_valid", bus.valid, 1);
    chk("s1_code", bus.code, 2);
    cyc(0, 3'd7, 8'h04, 8'hFF, 1);
    chk("s1_ackv", bus.valid, 0);
    chk("s1_ackp", bus.pending, 8'h00);

    // Lines 7 and 0 together: 7 first, 1-cycle gap, then 0
    cyc(0, 3'd7, 8'h00, 8'hFF, 0);
    cyc(0, 3'd7, 8'h81, 8'hFF, 0);
    cyc(0, 3'd7, 8'h81, 8'hFF, 0);
    chk("s2_code7", bus.code, 7);
    cyc(0, 3'd7, 8'h81, 8'hFF, 1);
    chk("s2_gap", bus.valid, 0);
    cyc(0, 3'd7, 8'h81, 8'hFF, 0);
    chk("s2_v0", bus.valid, 1);
    chk("s2_code0", bus.code, 0);
    cyc(0, 3'd7, 8'h81, 8'hFF, 1);

    // Disabled edges are dropped, and a held-high line does not re-arm
    cyc(0, 3'd3, 8'h00, 8'hFF, 0);
    cyc(0, 3'd3, 8'hFF, 8'hFF, 0);
    cyc(0, 3'd3, 8'hFF, 8'hFF, 0);
    chk("s3_dis_pend", bus.pending, 8'h00);
    cyc(0, 3'd7, 8'hFF, 8'hFF, 0);
    cyc(0, 3'd7, 8'hFF, 8'hFF, 0);
    chk("s3_held_pend", bus.pending, 8'h00);
    chk("s3_held_valid", bus.valid, 0);

    // Mask limits the offer; unmasking mid-offer does not retract it
    cyc(0, 3'd7, 8'h00, 8'h0F, 0);
    cyc(0, 3'd7, 8'h42, 8'h0F, 0);
    chk("s4_pend", bus.pending, 8'h42);
    cyc(0, 3'd7, 8'h42, 8'h0F, 0);
    chk("s4_code1", bus.code, 1);
    cyc(0, 3'd7, 8'h42, 8'hFF, 0);
    chk("s4_hold", bus.code, 1);
    cyc(0, 3'd7, 8'h42, 8'hFF, 1);
    cyc(0, 3'd7, 8'h42, 8'hFF, 0);
    chk("s4_code6", bus.code, 6);
    cyc(0, 3'd7, 8'h42, 8'hFF, 1);

    // Line 3 re-rises in its own ack cycle: set wins
    cyc(0, 3'd7, 8'h00, 8'hFF, 0);
    cyc(0, 3'd7, 8'h08, 8'hFF, 0);
    cyc(0, 3'd7, 8'h08, 8'hFF, 0);
    chk("s5_code3", bus.code, 3);
    cyc(0, 3'd7, 8'h00, 8'hFF, 0);
    cyc(0, 3'd7, 8'h08, 8'hFF, 1);
    chk("s5_keep", bus.pending, 8'h08);
    cyc(0, 3'd7, 8'h08, 8'hFF, 0);
    chk("s5_reoffer", bus.code, 3);
    cyc(0, 3'd7, 8'h08, 8'hFF, 1);

    // Reset during an offer
    cyc(0, 3'd7, 8'h00, 8'hFF, 0);
    cyc(0, 3'd7, 8'h30, 8'hFF, 0);
    cyc(0, 3'd7, 8'h30, 8'hFF, 0);
    chk("s6_pend", bus.pending, 8'h30);
    cyc(1, 3'd7, 8'h30, 8'hFF, 0);
    chk("s6_valid", bus.valid, 0);
    chk("s6_pendclr", bus.pending, 8'h00);
    chk("s6_code", bus.code, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] en;
      logic [7:0] rq, mk;
      en = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd7;
      rq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (m_prev & 8'($urandom));
      mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      cyc($urandom_range(0, 49) == 0, en, rq, mk, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
